spm_bank_arbiter: RTL and testbench
===================================

# spm_bank_arbiter

Shares a multi-bank, word-interleaved SPM between `NumReq` memory-style requesters, e.g. the narrow and wide `axi_to_mem` ports that front one SPM tile's `tc_sram` macros. Each bank runs its own round-robin arbitration, so requesters hitting different banks proceed in parallel. A one-cycle response pipeline routes read data back to the granted requester. A saturating conflict counter exposes bank contention to software via a status port.

## Interface
Parameters:
- `NumReq`, 2, number of requesters (≥1).
- `NumBanks`, 4, number of SRAM banks (power of two, ≥1).
- `AddrWidth`, 18, requester byte-address width.
- `DataWidth`, 64, word width in bits (power of two, ≥8).
- `WordsPerBank`, 1024, depth of each bank.
- `ByteOffW`, $clog2(DataWidth/8), derived, do not override.
- `BankSelW`, (NumBanks>1 ? $clog2(NumBanks) : 0), derived.
- `BankAddrW`, $clog2(WordsPerBank), derived.

Ports:
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in [NumReq]: request valid per requester.
- `gnt_o` out [NumReq]: grant, combinational from current cycle inputs.
- `addr_i` in [NumReq][AddrWidth]: byte address.
- `we_i` in [NumReq]: 1 = write.
- `wdata_i` in [NumReq][DataWidth]: write data.
- `strb_i` in [NumReq][DataWidth/8]: byte enables.
- `rvalid_o` out [NumReq]: response valid.
- `rdata_o` out [NumReq][DataWidth]: read data.
- `bank_req_o` out [NumBanks]: SRAM request.
- `bank_we_o` out [NumBanks]: SRAM write enable.
- `bank_addr_o` out [NumBanks][BankAddrW]: SRAM word address.
- `bank_wdata_o` out [NumBanks][DataWidth]: SRAM write data.
- `bank_be_o` out [NumBanks][DataWidth/8]: SRAM byte enables.
- `bank_rdata_i` in [NumBanks][DataWidth]: SRAM read data, latency 1.
- `stat_clear_i` in 1: clears the conflict counter.
- `stat_conflicts_o` out 32: saturating count of requester-cycles denied due to a bank conflict.

## Operation
- Address decode: bank = `addr_i[ByteOffW +: BankSelW]` (0 if NumBanks=1). Bank word address = `addr_i[ByteOffW+BankSelW +: BankAddrW]`. Bits above the decoded range are ignored.
- Per-bank arbiter: among requesters with `req_i` set targeting bank b, grant the first at or after pointer `rr_q[b]`, wrapping modulo NumReq. At most one grant per bank per cycle.
- A requester targets one bank, so it receives at most one grant per cycle. A non-requesting requester never gets `gnt_o`.
- When bank b grants requester k, `rr_q[b]` becomes (k+1) mod NumReq on the next edge. An idle bank keeps its pointer.
- Bank-side outputs come from the granted requester's fields. With no grant: `bank_req_o[b]`=0, other bank outputs '0.
- Requester contract: while `req_i` is high and `gnt_o` is low, all request fields stay stable. The arbiter does not check this.
- Response pipeline: every grant, read or write, registers (valid, bank, we). Next cycle `rvalid_o[k]`=1 for exactly one cycle. `rdata_o[k]` = `bank_rdata_i[bank]` for reads and '0 for writes. `rdata_o` is '0 whenever `rvalid_o` is 0.
- Conflict counter: each cycle, add the number of requesters with `req_i`=1 and `gnt_o`=0. Saturate at 2^32-1.
- `stat_clear_i` takes priority: that cycle's increment is discarded, and the counter reads 0 on the next cycle.

## Timing
- Grant latency 0 cycles (same cycle as `req_i`). Response latency exactly 1 cycle after grant.
- Throughput: one access per bank per cycle. Back-to-back grants to the same requester are allowed every cycle.
- Reset values: `rr_q` all 0, response valids 0, `rvalid_o` 0, `rdata_o` '0, counter 0.
- `bank_*_o` and `gnt_o` are combinational, so they reflect inputs during reset. Grants issued while `rst_i`=1 do not produce a response.
- Reset mid-operation: an in-flight response registered before the reset edge is dropped, and `rvalid_o` is 0 in the cycle after the reset.
- Simultaneous grant and read return to the same requester are legal: a new grant in cycle t and a response for the cycle t-1 grant both occur in cycle t.
- Wrap-around: pointer at NumReq-1 with requester NumReq-1 granted wraps to 0.

## Test plan
- Single read: NumReq=2, NumBanks=4, DataWidth=64. Req0 reads addr 0x18 (bank 3, word 0), memory holding 0xDEAD_BEEF -> same cycle `gnt_o`=01, `bank_req_o`=1000, `bank_addr_o[3]`=0. Next cycle `rvalid_o`=01, `rdata_o[0]`=0xDEAD_BEEF.
- Parallel banks: req0 writes 0x00 (bank 0), req1 writes 0x08 (bank 1), same cycle -> both granted, conflict counter unchanged. Next cycle `rvalid_o`=11 with `rdata_o` '0.
- Conflict and fairness: both requesters read 0x20 (bank 0) continuously for 4 cycles -> grants alternate req0, req1, req0, req1. Counter reads 4.
- Saturation and clear: counter preloaded to 0xFFFF_FFFF via a long conflict run with forced state -> stays at 0xFFFF_FFFF under further conflicts. Pulse `stat_clear_i` during a conflict -> counter reads 0 next cycle.
- Reset mid-flight: grant a read in cycle t and assert `rst_i` in cycle t -> `rvalid_o`=00 in cycle t+1, all pointers 0.
- Pipelined reads: req0 reads 0x00, 0x08, 0x10 on consecutive cycles -> three consecutive `rvalid_o[0]` pulses with the matching data in order.

Source files
------------

// File: rtl/spm_bank_arbiter.sv
// spm_bank_arbiter: per-bank round-robin arbitration of NumReq requesters onto a word-interleaved SPM
module spm_bank_arbiter #(
    parameter int NumReq       = 2,
    parameter int NumBanks     = 4,
    parameter int AddrWidth    = 18,
    parameter int DataWidth    = 64,
    parameter int WordsPerBank = 1024,
    parameter int ByteOffW     = $clog2(DataWidth/8),
    parameter int BankSelW     = (NumBanks > 1) ? $clog2(NumBanks) : 0,
    parameter int BankAddrW    = $clog2(WordsPerBank)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_i,
    output logic [NumReq-1:0]      gnt_o,
    input  logic [AddrWidth-1:0]   addr_i [NumReq],
    input  logic [NumReq-1:0]      we_i,
    input  logic [DataWidth-1:0]   wdata_i [NumReq],
    input  logic [DataWidth/8-1:0] strb_i [NumReq],
    output logic [NumReq-1:0]      rvalid_o,
    output logic [DataWidth-1:0]   rdata_o [NumReq],
    output logic [NumBanks-1:0]    bank_req_o,
    output logic [NumBanks-1:0]    bank_we_o,
    output logic [BankAddrW-1:0]   bank_addr_o [NumBanks],
    output logic [DataWidth-1:0]   bank_wdata_o [NumBanks],
    output logic [DataWidth/8-1:0] bank_be_o [NumBanks],
    input  logic [DataWidth-1:0]   bank_rdata_i [NumBanks],
    input  logic                   stat_clear_i,
    output logic [31:0]            stat_conflicts_o
);
    localparam int SelW = (BankSelW > 0) ? BankSelW : 1;
    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [SelW-1:0]      w_bank [NumReq];
    logic [BankAddrW-1:0] w_waddr [NumReq];
    logic [NumReq-1:0]    w_gnt;
    logic [NumBanks-1:0]  w_bgnt;
    logic [PtrW-1:0]      w_gidx [NumBanks];
    logic [32:0]          w_sum;
    logic                 w_unused;
    logic [PtrW-1:0]      r_rr [NumBanks];
    logic [NumReq-1:0]    r_vld;
    logic [NumReq-1:0]    r_we;
    logic [SelW-1:0]      r_bank [NumReq];
    logic [31:0]          r_conf;

    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            w_bank[k]  = (NumBanks > 1) ? addr_i[k][ByteOffW +: SelW] : '0;
            w_waddr[k] = addr_i[k][ByteOffW+BankSelW +: BankAddrW];
            w_unused   = w_unused ^ (^addr_i[k]);
        end
    end

    // Scan offsets from the bank pointer outward; the first hit wins the bank
    always_comb begin
        w_gnt  = '0;
        w_bgnt = '0;
        for (int b = 0; b < NumBanks; b++) begin
            w_gidx[b] = '0;
            for (int i = 0; i < NumReq; i++)
                for (int k = 0; k < NumReq; k++)
                    if (!w_bgnt[b] && req_i[k] && int'(w_bank[k]) == b && (int'(r_rr[b]) + i) % NumReq == k) begin
                        w_bgnt[b] = 1'b1;
                        w_gidx[b] = PtrW'(k);
                        w_gnt[k]  = 1'b1;
                    end
        end
    end

    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            bank_req_o[b]   = w_bgnt[b];
            bank_we_o[b]    = 1'b0;
            bank_addr_o[b]  = '0;
            bank_wdata_o[b] = '0;
            bank_be_o[b]    = '0;
            for (int k = 0; k < NumReq; k++)
                if (w_bgnt[b] && int'(w_gidx[b]) == k) begin
                    bank_we_o[b]    = we_i[k];
                    bank_addr_o[b]  = w_waddr[k];
                    bank_wdata_o[b] = wdata_i[k];
                    bank_be_o[b]    = strb_i[k];
                end
        end
    end

    always_comb begin
        w_sum = {1'b0, r_conf};
        for (int k = 0; k < NumReq; k++)
            w_sum = w_sum + 33'(req_i[k] & ~w_gnt[k]);
    end

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            rdata_o[k] = '0;
            for (int b = 0; b < NumBanks; b++)
                if (r_vld[k] && !r_we[k] && int'(r_bank[k]) == b)
                    rdata_o[k] = bank_rdata_i[b];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NumBanks; b++) r_rr[b] <= '0;
            for (int k = 0; k < NumReq; k++) r_bank[k] <= '0;
            r_vld  <= '0;
            r_we   <= '0;
            r_conf <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++)
                if (w_bgnt[b])
                    r_rr[b] <= (int'(w_gidx[b]) == NumReq - 1) ? '0 : w_gidx[b] + 1'b1;
            for (int k = 0; k < NumReq; k++) r_bank[k] <= w_bank[k];
            r_vld  <= w_gnt;
            r_we   <= we_i;
            r_conf <= stat_clear_i ? '0 : (w_sum[32] ? '1 : w_sum[31:0]);
        end
    end

    assign gnt_o            = w_gnt;
    assign rvalid_o         = r_vld;
    assign stat_conflicts_o = r_conf;
endmodule

// File: tb/tb_spm_bank_arbiter.sv
// tb_spm_bank_arbiter: directed plus random stimulus against a behavioural arbiter/SRAM model
module tb_spm_bank_arbiter;
    localparam int NR = 2, NB = 4, DW = 64, AW = 18, BW = 10;

    logic            clk = 1'b0, rst, clr;
    logic [NR-1:0]   req, gnt, we, rvalid;
    logic [AW-1:0]   addr [NR];
    logic [DW-1:0]   wdata [NR], rdata [NR];
    logic [7:0]      strb [NR];
    logic [NB-1:0]   breq, bwe;
    logic [BW-1:0]   baddr [NB];
    logic [DW-1:0]   bwdata [NB], brdata [NB];
    logic [7:0]      bbe [NB];
    logic [31:0]     conf;
    logic [63:0]     mem [NB][16];
    int              total = 0, bad = 0;
    int              ptr [NB];
    bit              pv [NR], pwe [NR];
    logic [63:0]     pdata [NR];
    longint          cnt;

    always #5 clk = ~clk;

    spm_bank_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid), .rdata_o(rdata),
        .bank_req_o(breq), .bank_we_o(bwe), .bank_addr_o(baddr), .bank_wdata_o(bwdata),
        .bank_be_o(bbe), .bank_rdata_i(brdata), .stat_clear_i(clr), .stat_conflicts_o(conf)
    );

    // SRAM banks with one-cycle read latency and byte-enabled writes
    always @(posedge clk)
        for (int b = 0; b < NB; b++)
            if (breq[b]) begin
                if (bwe[b]) begin
                    for (int y = 0; y < 8; y++)
                        if (bbe[b][y]) mem[b][baddr[b][3:0]][y*8 +: 8] = bwdata[b][y*8 +: 8];
                end else begin
                    brdata[b] <= mem[b][baddr[b][3:0]];
                end
            end

    function automatic int bank_of(logic [AW-1:0] a);
        return int'(a[4:3]);
    endfunction

    function automatic int word_of(logic [AW-1:0] a);
        return int'(a[14:5]);
    endfunction

    task automatic chk(string tag, int idx, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic set(int k, bit r, logic [AW-1:0] a, bit w, logic [63:0] d, logic [7:0] s);
        req[k] = r; addr[k] = a; we[k] = w; wdata[k] = d; strb[k] = s;
    endtask

    task automatic idle();
        for (int k = 0; k < NR; k++) set(k, 0, '0, 0, '0, '0);
    endtask

    // Check all outputs against the model for the current inputs, then advance one clock
    task automatic cycle();
        logic [NR-1:0] eg;
        logic [NB-1:0] eb;
        int gi [NB];
        int den;
        #1;
        eg = '0; eb = '0; den = 0;
        for (int b = 0; b < NB; b++) begin
            gi[b] = -1;
            for (int k = 0; k < NR; k++)
                if (req[k] && bank_of(addr[k]) == b &&
                    (gi[b] < 0 || (k - ptr[b] + NR) % NR < (gi[b] - ptr[b] + NR) % NR))
                    gi[b] = k;
            if (gi[b] >= 0) begin eb[b] = 1'b1; eg[gi[b]] = 1'b1; end
        end
        chk("gnt", 0, 64'(gnt), 64'(eg));
        chk("bank_req", 0, 64'(breq), 64'(eb));
        for (int b = 0; b < NB; b++) begin
            if (gi[b] >= 0) begin
                chk("bank_we", b, 64'(bwe[b]), 64'(we[gi[b]]));
                chk("bank_addr", b, 64'(baddr[b]), 64'(word_of(addr[gi[b]])));
                chk("bank_wdata", b, bwdata[b], wdata[gi[b]]);
                chk("bank_be", b, 64'(bbe[b]), 64'(strb[gi[b]]));
            end else begin
                chk("bank_idle", b, {bwe[b], baddr[b], bbe[b]} | 64'(bwdata[b] != 0), 64'd0);
            end
        end
        for (int k = 0; k < NR; k++) begin
            chk("rvalid", k, 64'(rvalid[k]), 64'(pv[k]));
            chk("rdata", k, rdata[k], (pv[k] && !pwe[k]) ? pdata[k] : 64'd0);
            if (req[k] && !eg[k]) den++;
        end
        chk("conflicts", 0, 64'(conf), 64'(cnt));
        if (rst) begin
            for (int b = 0; b < NB; b++) ptr[b] = 0;
            for (int k = 0; k < NR; k++) pv[k] = 0;
            cnt = 0;
        end else begin
            for (int b = 0; b < NB; b++) if (gi[b] >= 0) ptr[b] = (gi[b] + 1) % NR;
            for (int k = 0; k < NR; k++) begin
                pv[k] = eg[k];
                pwe[k] = we[k];
                pdata[k] = mem[bank_of(addr[k])][word_of(addr[k]) % 16];
            end
            cnt = clr ? 0 : ((cnt + den > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : cnt + den);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] a;
        rst = 1'b1; clr = 1'b0; idle();
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 16; w++) mem[b][w] = {$urandom, $urandom};
        mem[3][0] = 64'hDEAD_BEEF;
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        for (int k = 0; k < NR; k++) begin pv[k] = 0; pwe[k] = 0; pdata[k] = '0; end
        cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        // single read from bank 3 word 0
        set(0, 1, 18'h18, 0, '0, '0);
        cycle();
        idle();
        chk("single_rdata", 0, rdata[0], 64'hDEAD_BEEF);
        cycle();
        // parallel writes to banks 0 and 1
        set(0, 1, 18'h00, 1, 64'h1111_2222_3333_4444, 8'hFF);
        set(1, 1, 18'h08, 1, 64'h5555_6666_7777_8888, 8'h0F);
        cycle();
        idle();
        cycle();
        // fresh pointers, then both fight over bank 0
        rst = 1'b1; cycle(); rst = 1'b0;
        set(0, 1, 18'h20, 0, '0, '0);
        set(1, 1, 18'h20, 0, '0, '0);
        repeat (4) cycle();
        chk("conflict_cnt", 0, 64'(conf), 64'd4);
        // saturation from a preloaded count, then clear during a conflict
        force dut.r_conf = 32'hFFFF_FFFE;
        #1;
        release dut.r_conf;
        cnt = 64'hFFFF_FFFE;
        set(0, 1, 18'h28, 0, '0, '0);
        set(1, 1, 18'h28, 0, '0, '0);
        repeat (3) cycle();
        chk("saturated", 0, 64'(conf), 64'hFFFF_FFFF);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("cleared", 0, 64'(conf), 64'd0);
        cycle();
        // reset arriving with a fresh read grant drops its response
        idle();
        set(0, 1, 18'h30, 0, '0, '0);
        rst = 1'b1; cycle(); rst = 1'b0;
        idle();
        chk("rst_rvalid", 0, 64'(rvalid), 64'd0);
        cycle();
        // back-to-back reads from one requester
        set(0, 1, 18'h00, 0, '0, '0); cycle();
        set(0, 1, 18'h08, 0, '0, '0); cycle();
        set(0, 1, 18'h10, 0, '0, '0); cycle();
        idle(); cycle(); cycle();
        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NR; k++) begin
                a = 18'($urandom);
                a[14:9] = '0;
                set(k, $urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
                    {$urandom, $urandom}, 8'($urandom));
            end
            clr = $urandom_range(0, 31) == 0;
            rst = $urandom_range(0, 63) == 0;
            cycle();
        end
        rst = 1'b0; clr = 1'b0; idle();
        cycle(); cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
